regfile_op_sequencer: RTL and testbench
=======================================

Name: regfile_op_sequencer

Overview:
- Command-driven micro-sequencer for the 4x8 register file.
- Accepts one operation per command: opcode, two source indices, destination index, immediate.
- Drives the file's two read ports, computes an 8-bit result with a small ALU, and writes the result back through the file's write port.
- Sits between a command master (testbench, host FSM) and the register file; it is the only writer of the file.

Parameters:
- DATA_W, 8, register/data width.
- IDX_W, 2, register index width (2^IDX_W entries).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- clear  in  1  reset: one clock domain; synchronous, active-low (clear=0 resets on the next rising edge).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 0 NOP, 1 MOV, 2 LDI, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR.
- cmd_dst  in  IDX_W  destination register index.
- cmd_src1  in  IDX_W  first source index.
- cmd_src2  in  IDX_W  second source index.
- cmd_imm  in  DATA_W  immediate for LDI.
- rf_read_index1  out  IDX_W  to file read port 1.
- rf_read_index2  out  IDX_W  to file read port 2.
- rf_read_data1  in  DATA_W  from file read port 1 (combinational).
- rf_read_data2  in  DATA_W  from file read port 2 (combinational).
- rf_write  out  1  file write strobe.
- rf_write_index  out  IDX_W  file write index.
- rf_write_data  out  DATA_W  file write data.
- done  out  1  one-cycle pulse when a command completes.
- result  out  DATA_W  last computed result, held until next completion.
- flag_zero  out  1  result==0, held.
- flag_carry  out  1  ADD carry-out / SUB borrow, else 0; held.

Behaviour:
- FSM states: IDLE, READ, EXEC, WRITE.
- Reset (clear=0 at a rising edge): state=IDLE; latched command, operand registers, result, flags and index outputs all cleared to 0; done=0.
- cmd_ready = (state==IDLE) && clear. It is low throughout any cycle with clear=0.
- Handshake:
  - Command accepted at a rising edge where cmd_valid && cmd_ready.
  - On acceptance, all cmd_* fields are latched; the master may change them afterwards.
  - cmd_valid while not ready is ignored, not queued.
- Timing, acceptance edge = T:
  - Cycle T+1, READ: rf_read_index1/2 driven from latched src1/src2. rf_read_data1/2 are captured into operand registers at the end of the cycle.
  - Cycle T+2, EXEC: ALU evaluates the operands. result, flag_zero and flag_carry are registered at the end of the cycle.
  - Cycle T+3, WRITE: rf_write_index = latched dst, rf_write_data = result. rf_write = (op!=NOP) && clear, combinational. done=1 for exactly this cycle, NOP included.
  - Next edge: state returns to IDLE, so cmd_ready is high in cycle T+4.
  - Throughput is one command per 4 cycles.
- rf_write is held for the whole WRITE cycle so the file's falling-edge write samples stable index and data mid-cycle.
- Index outputs hold their last values in IDLE.
- ALU rules (DATA_W bits, unsigned):
  - MOV: src1.
  - LDI: imm; source reads are don't-care.
  - ADD: (src1+src2) mod 2^DATA_W; carry = bit DATA_W of the sum.
  - SUB: (src1-src2) mod 2^DATA_W; carry = 1 iff src1<src2.
  - AND / OR / XOR: bitwise; carry = 0.
  - NOP: result, flags and file contents unchanged.
- Boundary cases:
  - src1==src2 and dst==src are legal. Reads complete before the write, so the old value is used.
  - A back-to-back command reading the previous dst sees the new value: its read occurs at T+5 or later, after the falling-edge write at T+3.
  - Reset mid-operation: clear=0 in any cycle forces rf_write=0 immediately. The next edge returns to IDLE; the aborted command never writes and never pulses done.
  - cmd_valid held high continuously: commands are accepted every 4th edge, each field sampled only at acceptance.

Test Plan:
- Hold clear=0 for 2 cycles, cmd_valid=1 -> no acceptance; cmd_ready, rf_write, done, result, flags all 0. Release -> cmd_ready=1 in the next cycle.
- LDI dst=2 imm=0x5A accepted at T -> rf_write=1, rf_write_index=2, rf_write_data=0x5A, done=1 at T+3 only; cmd_ready=1 at T+4; file r2=0x5A.
- r0=0xF0, r1=0x20; ADD dst=3 src1=0 src2=1 -> r3=0x10, flag_carry=1, flag_zero=0. Then SUB dst=3 src1=1 src2=0 -> r3=0x30, flag_carry=1.
- r1=0x20; XOR dst=1 src1=1 src2=1 -> r1=0x00, flag_zero=1, flag_carry=0. NOP afterwards -> done pulse, rf_write=0, result/flags unchanged.
- cmd_valid held high with MOV r0<-r2 then ADD r1<-r0+r0 (r2=0x5A) -> acceptances exactly 4 cycles apart; r0=0x5A, r1=0xB4.
- Accept ADD, drive clear=0 during the WRITE cycle -> rf_write=0 that cycle, no done, target register unchanged, state IDLE after the edge.

Source files
------------

// File: rtl/regfile_op_sequencer_if.sv
// Command channel between a command master and the register-file op sequencer.
// The master presents one operation at a time; the sequencer raises cmd_ready when idle.
interface regfile_op_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [2:0]        cmd_op;
    logic [IDX_W-1:0]  cmd_dst;
    logic [IDX_W-1:0]  cmd_src1;
    logic [IDX_W-1:0]  cmd_src2;
    logic [DATA_W-1:0] cmd_imm;

    modport master (
        output cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_dst, cmd_src1, cmd_src2, cmd_imm,
        output cmd_ready
    );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Four-phase micro-sequencer: IDLE -> READ -> EXEC -> WRITE, one command per 4 cycles.
// Reads two registers, runs a small ALU, writes the result back to the register file.
module regfile_op_sequencer #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2
) (
    input  logic              clock,
    input  logic              clear,
    regfile_op_sequencer_if.slave cmd,
    output logic [IDX_W-1:0]  rf_read_index1,
    output logic [IDX_W-1:0]  rf_read_index2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic              rf_write,
    output logic [IDX_W-1:0]  rf_write_index,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              flag_zero,
    output logic              flag_carry
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_EXEC  = 2'd2;
    localparam logic [1:0] ST_WRITE = 2'd3;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_MOV = 3'd1;
    localparam logic [2:0] OP_LDI = 3'd2;
    localparam logic [2:0] OP_ADD = 3'd3;
    localparam logic [2:0] OP_SUB = 3'd4;
    localparam logic [2:0] OP_AND = 3'd5;
    localparam logic [2:0] OP_OR  = 3'd6;
    localparam logic [2:0] OP_XOR = 3'd7;

    logic [1:0]        state;
    logic [2:0]        op_q;
    logic [IDX_W-1:0]  dst_q;
    logic [DATA_W-1:0] imm_q;
    logic [DATA_W-1:0] opnd1;
    logic [DATA_W-1:0] opnd2;
    logic [DATA_W-1:0] alu_res;
    logic              alu_carry;
    logic [DATA_W:0]   alu_wide;

    assign cmd.cmd_ready  = clear && (state == ST_IDLE);
    assign done           = clear && (state == ST_WRITE);
    assign rf_write       = clear && (state == ST_WRITE) && (op_q != OP_NOP);
    assign rf_write_index = dst_q;
    assign rf_write_data  = result;

    // NOP falls through to the held result/flags so EXEC can register unconditionally-safe values.
    always_comb begin
        alu_wide  = '0;
        alu_res   = result;
        alu_carry = flag_carry;
        case (op_q)
            OP_MOV: begin
                alu_res   = opnd1;
                alu_carry = 1'b0;
            end
            OP_LDI: begin
                alu_res   = imm_q;
                alu_carry = 1'b0;
            end
            OP_ADD: begin
                alu_wide  = {1'b0, opnd1} + {1'b0, opnd2};
                alu_res   = alu_wide[DATA_W-1:0];
                alu_carry = alu_wide[DATA_W];
            end
            OP_SUB: begin
                alu_wide  = {1'b0, opnd1} - {1'b0, opnd2};
                alu_res   = alu_wide[DATA_W-1:0];
                alu_carry = alu_wide[DATA_W];
            end
            OP_AND: begin
                alu_res   = opnd1 & opnd2;
                alu_carry = 1'b0;
            end
            OP_OR: begin
                alu_res   = opnd1 | opnd2;
                alu_carry = 1'b0;
            end
            OP_XOR: begin
                alu_res   = opnd1 ^ opnd2;
                alu_carry = 1'b0;
            end
            default: begin
                alu_res   = result;
                alu_carry = flag_carry;
            end
        endcase
    end

    // Source indices are loaded straight into the read-port registers at acceptance,
    // so they are already stable for the whole READ cycle and hold afterwards.
    always_ff @(posedge clock) begin
        if (!clear) begin
            state          <= ST_IDLE;
            op_q           <= OP_NOP;
            dst_q          <= '0;
            imm_q          <= '0;
            opnd1          <= '0;
            opnd2          <= '0;
            result         <= '0;
            flag_zero      <= 1'b0;
            flag_carry     <= 1'b0;
            rf_read_index1 <= '0;
            rf_read_index2 <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_q           <= cmd.cmd_op;
                        dst_q          <= cmd.cmd_dst;
                        imm_q          <= cmd.cmd_imm;
                        rf_read_index1 <= cmd.cmd_src1;
                        rf_read_index2 <= cmd.cmd_src2;
                        state          <= ST_READ;
                    end
                end
                ST_READ: begin
                    opnd1 <= rf_read_data1;
                    opnd2 <= rf_read_data2;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op_q != OP_NOP) begin
                        result     <= alu_res;
                        flag_zero  <= (alu_res == '0);
                        flag_carry <= alu_carry;
                    end
                    state <= ST_WRITE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Scoreboard bench: issued commands push expected results from a plain-arithmetic model;
// a negedge monitor pops one entry for every done pulse and compares.
module tb_regfile_op_sequencer;
    logic       clock;
    logic       clear;
    logic [1:0] rf_read_index1, rf_read_index2, rf_write_index;
    logic [7:0] rf_read_data1, rf_read_data2, rf_write_data, result;
    logic       rf_write, done, flag_zero, flag_carry;

    regfile_op_sequencer_if #(.DATA_W(8), .IDX_W(2)) cmd_bus ();

    regfile_op_sequencer #(.DATA_W(8), .IDX_W(2)) dut (
        .clock          (clock),
        .clear          (clear),
        .cmd            (cmd_bus.slave),
        .rf_read_index1 (rf_read_index1),
        .rf_read_index2 (rf_read_index2),
        .rf_read_data1  (rf_read_data1),
        .rf_read_data2  (rf_read_data2),
        .rf_write       (rf_write),
        .rf_write_index (rf_write_index),
        .rf_write_data  (rf_write_data),
        .done           (done),
        .result         (result),
        .flag_zero      (flag_zero),
        .flag_carry     (flag_carry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int prev_acc = 0;
    int last_acc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Register file with combinational reads and a falling-edge write.
    logic [7:0] tb_rf [4];
    assign rf_read_data1 = tb_rf[rf_read_index1];
    assign rf_read_data2 = tb_rf[rf_read_index2];
    always @(negedge clock) begin
        if (rf_write === 1'b1) tb_rf[rf_write_index] = rf_write_data;
    end

    typedef struct {
        int         acc;
        logic       wr;
        logic [1:0] idx;
        logic [7:0] data;
        logic [7:0] res;
        logic       z;
        logic       c;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int   model_regs [4];
    int   model_res;
    logic model_z;
    logic model_c;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    function automatic exp_t model_step(input int op, input int dst, input int s1, input int s2, input int imm);
        exp_t e;
        int a, b, r;
        logic c;
        a = model_regs[s1];
        b = model_regs[s2];
        r = 0;
        c = 1'b0;
        e.acc = 0;
        e.idx = 2'(dst);
        if (op == 0) begin
            e.wr   = 1'b0;
            e.data = 8'(model_res);
            e.res  = 8'(model_res);
            e.z    = model_z;
            e.c    = model_c;
            return e;
        end
        case (op)
            1: r = a;
            2: r = imm;
            3: begin r = (a + b) % 256; c = (a + b) > 255; end
            4: begin r = (a - b + 256) % 256; c = a < b; end
            5: r = a & b;
            6: r = a | b;
            default: r = a ^ b;
        endcase
        model_regs[dst] = r;
        model_res = r;
        model_z   = (r == 0);
        model_c   = c;
        e.wr   = 1'b1;
        e.data = 8'(r);
        e.res  = 8'(r);
        e.z    = model_z;
        e.c    = c;
        return e;
    endfunction

    // Monitor: every done pulse must match the oldest outstanding command.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_output("unexpected_done", 32'(done), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check_output("done_cycle", 32'(cyc), 32'(mon_e.acc + 2));
                check_output("rf_write", 32'(rf_write), 32'(mon_e.wr));
                if (mon_e.wr) begin
                    check_output("rf_write_index", 32'(rf_write_index), 32'(mon_e.idx));
                    check_output("rf_write_data", 32'(rf_write_data), 32'(mon_e.data));
                end
                check_output("result", 32'(result), 32'(mon_e.res));
                check_output("flag_zero", 32'(flag_zero), 32'(mon_e.z));
                check_output("flag_carry", 32'(flag_carry), 32'(mon_e.c));
                check_output("ready_in_write", 32'(cmd_bus.cmd_ready), 32'd0);
            end
        end
    end

    // Called at a falling edge; returns at the falling edge of the READ cycle.
    task automatic apply_stimulus(input int op, input int dst, input int s1, input int s2,
                                  input int imm, input bit hold_valid, input bit track);
        int waited;
        exp_t e;
        cmd_bus.cmd_op    = 3'(op);
        cmd_bus.cmd_dst   = 2'(dst);
        cmd_bus.cmd_src1  = 2'(s1);
        cmd_bus.cmd_src2  = 2'(s2);
        cmd_bus.cmd_imm   = 8'(imm);
        cmd_bus.cmd_valid = 1'b1;
        waited = 0;
        while (cmd_bus.cmd_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check_output("accept_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        if (cmd_bus.cmd_ready !== 1'b1) begin
            cmd_bus.cmd_valid = 1'b0;
            return;
        end
        prev_acc = last_acc;
        last_acc = cyc + 1;
        if (track) begin
            e = model_step(op, dst, s1, s2, imm);
            e.acc = last_acc;
            exp_q.push_back(e);
        end
        @(negedge clock);
        cmd_bus.cmd_op    = 3'($urandom);
        cmd_bus.cmd_dst   = 2'($urandom);
        cmd_bus.cmd_src1  = 2'($urandom);
        cmd_bus.cmd_src2  = 2'($urandom);
        cmd_bus.cmd_imm   = 8'($urandom);
        cmd_bus.cmd_valid = hold_valid;
    endtask

    task automatic drain();
        int waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        check_output("drain", 32'(exp_q.size()), 32'd0);
        @(negedge clock);
    endtask

    task automatic check_file(input string name);
        for (int k = 0; k < 4; k++)
            check_output($sformatf("%s_r%0d", name, k), 32'(tb_rf[k]), 32'(model_regs[k]));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            tb_rf[k] = 8'h00;
            model_regs[k] = 0;
        end
        model_res = 0;
        model_z   = 1'b0;
        model_c   = 1'b0;
        clear = 1'b0;
        cmd_bus.cmd_valid = 1'b1;
        cmd_bus.cmd_op    = 3'd2;
        cmd_bus.cmd_dst   = 2'd1;
        cmd_bus.cmd_src1  = 2'd0;
        cmd_bus.cmd_src2  = 2'd0;
        cmd_bus.cmd_imm   = 8'hA5;

        // Reset held two cycles with a command pending: nothing may be accepted.
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            check_output("rst_ready", 32'(cmd_bus.cmd_ready), 32'd0);
            check_output("rst_rf_write", 32'(rf_write), 32'd0);
            check_output("rst_done", 32'(done), 32'd0);
            check_output("rst_result", 32'(result), 32'd0);
            check_output("rst_flags", 32'({flag_zero, flag_carry}), 32'd0);
            check_output("rst_wr_index", 32'(rf_write_index), 32'd0);
        end
        clear = 1'b1;
        cmd_bus.cmd_valid = 1'b0;
        @(negedge clock);
        check_output("ready_after_reset", 32'(cmd_bus.cmd_ready), 32'd1);
        check_output("no_accept_in_reset", 32'(tb_rf[1]), 32'd0);

        apply_stimulus(2, 2, 0, 0, 8'h5A, 1'b0, 1'b1);
        drain();
        check_output("ldi_r2", 32'(tb_rf[2]), 32'h5A);

        apply_stimulus(2, 0, 0, 0, 8'hF0, 1'b0, 1'b1);
        apply_stimulus(2, 1, 0, 0, 8'h20, 1'b0, 1'b1);
        apply_stimulus(3, 3, 0, 1, 0, 1'b0, 1'b1);
        drain();
        check_output("add_r3", 32'(tb_rf[3]), 32'h10);
        apply_stimulus(4, 3, 1, 0, 0, 1'b0, 1'b1);
        drain();
        check_output("sub_r3", 32'(tb_rf[3]), 32'h30);

        apply_stimulus(7, 1, 1, 1, 0, 1'b0, 1'b1);
        apply_stimulus(0, 2, 3, 3, 8'hFF, 1'b0, 1'b1);
        drain();
        check_output("xor_r1", 32'(tb_rf[1]), 32'h00);
        check_output("nop_keeps_r2", 32'(tb_rf[2]), 32'h5A);

        // Valid held high across two commands: acceptances exactly four edges apart.
        apply_stimulus(1, 0, 2, 0, 0, 1'b1, 1'b1);
        apply_stimulus(3, 1, 0, 0, 0, 1'b1, 1'b1);
        check_output("held_valid_spacing", 32'(last_acc - prev_acc), 32'd4);
        cmd_bus.cmd_valid = 1'b0;
        drain();
        check_output("mov_r0", 32'(tb_rf[0]), 32'h5A);
        check_output("add_r1", 32'(tb_rf[1]), 32'hB4);

        // Abort an ADD by pulling clear low during its WRITE cycle.
        apply_stimulus(3, 2, 0, 1, 0, 1'b0, 1'b0);
        @(posedge clock);
        @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        check_output("abort_rf_write", 32'(rf_write), 32'd0);
        check_output("abort_done", 32'(done), 32'd0);
        @(posedge clock);
        #1 clear = 1'b1;
        model_res = 0;
        model_z   = 1'b0;
        model_c   = 1'b0;
        @(negedge clock);
        check_output("abort_ready", 32'(cmd_bus.cmd_ready), 32'd1);
        check_output("abort_result", 32'(result), 32'd0);
        check_output("abort_r2", 32'(tb_rf[2]), 32'h5A);

        // Randomized traffic against the model.
        for (int n = 0; n < 40; n++) begin
            apply_stimulus(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                           int'($urandom_range(0, 255)), 1'($urandom), 1'b1);
            if (cmd_bus.cmd_valid == 1'b0) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge clock);
            end
        end
        cmd_bus.cmd_valid = 1'b0;
        drain();
        check_file("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
